// File: rtl/apb_arb_pkg.sv
// Shared definitions for the APB master arbiter.
//   APB_DW / APB_AW : APB data and address widths
//   NSLOT           : number of one-hot PSEL slots
//   arb_state_e     : transfer sequencer state encoding
//   ptr_width()     : width of the round-robin pointer for a given requester count
package apb_arb_pkg;

  localparam int APB_DW = 32;
  localparam int APB_AW = 32;
  localparam int NSLOT  = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } arb_state_e;

  // A single requester still needs a 1-bit pointer to keep the vector legal.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_master_arbiter_if.sv
// APB3 bus between the arbiter (master) and the slave fabric (slave).
//   PADDR, PSEL[15:0], PENABLE, PWRITE, PWDATA : master -> slave
//   PRDATA, PREADY, PSLVERR                    : slave -> master
interface apb_master_arbiter_if;
  import apb_arb_pkg::*;

  logic [APB_AW-1:0] PADDR;
  logic [NSLOT-1:0]  PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [APB_DW-1:0] PWDATA;
  logic [APB_DW-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );

endinterface

// File: rtl/apb_rr_arbiter.sv
// Combinational masked round-robin pick.
//   req   : per-requester request
//   mask  : requesters excluded from this pick
//   ptr   : index where the search starts (wraps)
//   gnt   : one-hot grant of the first eligible requester at or after ptr
//   valid : a grant was made
module apb_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] mask,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic            valid
);

  int idx;

  always_comb begin
    gnt   = '0;
    valid = 1'b0;
    idx   = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = (int'(ptr) + i) % NREQ;
      if (!valid && req[idx] && !mask[idx]) begin
        gnt[idx] = 1'b1;
        valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter sharing one APB3 master port between NREQ requesters.
//   PCLK, PRESET                     : clock, synchronous active-high reset
//   REQ/REQ_WRITE/REQ_ADDR/REQ_WDATA : per-requester command (32-bit lanes)
//   DONE/RDATA/RESP_ERR              : one-cycle completion to the winner
//   apb (master modport)             : APB bus with 16-way one-hot PSEL
// Optional: define APB_ARB_TIMEOUT_EN to end an ACCESS phase with an error
// after TIMEOUT cycles without PREADY.
//
// state     | meaning
// ST_IDLE   | arbitrate; latch winner's command into the APB output regs
// ST_SETUP  | PSEL driven, PENABLE low (one cycle)
// ST_ACCESS | PENABLE high, waiting for PREADY (or timeout)
module apb_master_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int SLOT_LSB = 24,
  parameter int TIMEOUT  = 255
) (
  input  logic                     PCLK,
  input  logic                     PRESET,
  input  logic [NREQ-1:0]          REQ,
  input  logic [NREQ-1:0]          REQ_WRITE,
  input  logic [NREQ*APB_AW-1:0]   REQ_ADDR,
  input  logic [NREQ*APB_DW-1:0]   REQ_WDATA,
  output logic [NREQ-1:0]          DONE,
  output logic [APB_DW-1:0]        RDATA,
  output logic                     RESP_ERR,
  apb_master_arbiter_if.master     apb
);

  localparam int PW = ptr_width(NREQ);

  arb_state_e        state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [APB_AW-1:0] paddr_q, paddr_d;
  logic [NSLOT-1:0]  psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [APB_DW-1:0] pwdata_q, pwdata_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic [APB_DW-1:0] rdata_q, rdata_d;
  logic              resp_err_q, resp_err_d;

  logic [NREQ-1:0]   rr_gnt;
  logic              rr_valid;
  logic [APB_AW-1:0] win_addr;
  logic [APB_DW-1:0] win_wdata;
  logic              win_write;
  int                win_idx;
  logic              tmo_hit;

  // The requester finishing this cycle still has REQ high; masking it keeps
  // it from being re-granted before it can drop the request.
  apb_rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_rr (
    .req   (REQ),
    .mask  (done_q),
    .ptr   (ptr_q),
    .gnt   (rr_gnt),
    .valid (rr_valid)
  );

  always_comb begin
    win_addr  = '0;
    win_wdata = '0;
    win_write = 1'b0;
    win_idx   = 0;
    for (int i = 0; i < NREQ; i++) begin
      if (rr_gnt[i]) begin
        win_addr  = REQ_ADDR[i*APB_AW +: APB_AW];
        win_wdata = REQ_WDATA[i*APB_DW +: APB_DW];
        win_write = REQ_WRITE[i];
        win_idx   = i;
      end
    end
  end

`ifdef APB_ARB_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] tmo_q, tmo_d;

  // Counts ACCESS cycles from 0; the cycle holding TIMEOUT-1 is the last one.
  always_comb begin
    tmo_d = tmo_q;
    if (state_q == ST_SETUP) begin
      tmo_d = '0;
    end else if (state_q == ST_ACCESS && tmo_q != 8'hFF) begin
      tmo_d = tmo_q + 8'd1;
    end
  end

  assign tmo_hit = (state_q == ST_ACCESS) && (tmo_q == TMO_LAST);

  always_ff @(posedge PCLK) begin
    if (PRESET) tmo_q <= '0;
    else        tmo_q <= tmo_d;
  end
`else
  logic [7:0] unused_timeout;
  assign unused_timeout = 8'(TIMEOUT);
  assign tmo_hit        = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gnt_d      = gnt_q;
    paddr_d    = paddr_q;
    psel_d     = psel_q;
    penable_d  = penable_q;
    pwrite_d   = pwrite_q;
    pwdata_d   = pwdata_q;
    done_d     = '0;
    rdata_d    = '0;
    resp_err_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (rr_valid) begin
          gnt_d    = rr_gnt;
          paddr_d  = win_addr;
          pwdata_d = win_wdata;
          pwrite_d = win_write;
          psel_d   = {{(NSLOT-1){1'b0}}, 1'b1} << win_addr[SLOT_LSB +: 4];
          ptr_d    = PW'((win_idx + 1) % NREQ);
          state_d  = ST_SETUP;
        end
      end
      ST_SETUP: begin
        penable_d = 1'b1;
        state_d   = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (apb.PREADY || tmo_hit) begin
          done_d    = gnt_q;
          psel_d    = '0;
          penable_d = 1'b0;
          state_d   = ST_IDLE;
          if (apb.PREADY) begin
            rdata_d    = pwrite_q ? '0 : apb.PRDATA;
            resp_err_d = apb.PSLVERR;
          end else begin
            resp_err_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      gnt_q      <= '0;
      paddr_q    <= '0;
      psel_q     <= '0;
      penable_q  <= 1'b0;
      pwrite_q   <= 1'b0;
      pwdata_q   <= '0;
      done_q     <= '0;
      rdata_q    <= '0;
      resp_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      paddr_q    <= paddr_d;
      psel_q     <= psel_d;
      penable_q  <= penable_d;
      pwrite_q   <= pwrite_d;
      pwdata_q   <= pwdata_d;
      done_q     <= done_d;
      rdata_q    <= rdata_d;
      resp_err_q <= resp_err_d;
    end
  end

  assign apb.PADDR   = paddr_q;
  assign apb.PSEL    = psel_q;
  assign apb.PENABLE = penable_q;
  assign apb.PWRITE  = pwrite_q;
  assign apb.PWDATA  = pwdata_q;
  assign DONE        = done_q;
  assign RDATA       = rdata_q;
  assign RESP_ERR    = resp_err_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed bench for apb_master_arbiter (NREQ=4, SLOT_LSB=24, TIMEOUT=16).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_apb_master_arbiter;

  localparam int NREQ = 4;

  logic                 PCLK;
  logic                 PRESET;
  logic [NREQ-1:0]      REQ;
  logic [NREQ-1:0]      REQ_WRITE;
  logic [NREQ*32-1:0]   REQ_ADDR;
  logic [NREQ*32-1:0]   REQ_WDATA;
  logic [NREQ-1:0]      DONE;
  logic [31:0]          RDATA;
  logic                 RESP_ERR;

  int n_checks = 0;
  int n_errors = 0;

  apb_master_arbiter_if apb ();

  apb_master_arbiter #(
    .NREQ     (NREQ),
    .SLOT_LSB (24),
    .TIMEOUT  (16)
  ) dut (
    .PCLK      (PCLK),
    .PRESET    (PRESET),
    .REQ       (REQ),
    .REQ_WRITE (REQ_WRITE),
    .REQ_ADDR  (REQ_ADDR),
    .REQ_WDATA (REQ_WDATA),
    .DONE      (DONE),
    .RDATA     (RDATA),
    .RESP_ERR  (RESP_ERR),
    .apb       (apb)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_cmd(input int i, input logic wr, input logic [31:0] a, input logic [31:0] d);
    REQ_WRITE[i]         = wr;
    REQ_ADDR[i*32 +: 32]  = a;
    REQ_WDATA[i*32 +: 32] = d;
  endtask

  initial begin
    PRESET      = 1'b1;
    REQ         = '0;
    REQ_WRITE   = '0;
    REQ_ADDR    = '0;
    REQ_WDATA   = '0;
    apb.PRDATA  = 32'hFFFF_FFFF;
    apb.PREADY  = 1'b0;
    apb.PSLVERR = 1'b0;
    tick();
    tick();

    // Reset state
    chk("rst_psel",    64'(apb.PSEL),    64'h0);
    chk("rst_penable", 64'(apb.PENABLE), 64'h0);
    chk("rst_paddr",   64'(apb.PADDR),   64'h0);
    chk("rst_done",    64'(DONE),        64'h0);
    chk("rst_rdata",   64'(RDATA),       64'h0);
    chk("rst_err",     64'(RESP_ERR),    64'h0);
    PRESET = 1'b0;
    tick();
    chk("idle_psel", 64'(apb.PSEL), 64'h0);

    // 1. Single zero-wait write from requester 0 (PRDATA nonzero must not leak)
    set_cmd(0, 1'b1, 32'h0300_0010, 32'hDEAD_BEEF);
    REQ        = 4'b0001;
    apb.PREADY = 1'b1;
    tick();
    chk("w_setup_psel",    64'(apb.PSEL),    64'h0008);
    chk("w_setup_penable", 64'(apb.PENABLE), 64'h0);
    chk("w_setup_paddr",   64'(apb.PADDR),   64'h0300_0010);
    chk("w_setup_pwrite",  64'(apb.PWRITE),  64'h1);
    chk("w_setup_pwdata",  64'(apb.PWDATA),  64'hDEAD_BEEF);
    chk("w_setup_done",    64'(DONE),        64'h0);
    tick();
    chk("w_access_penable", 64'(apb.PENABLE), 64'h1);
    chk("w_access_psel",    64'(apb.PSEL),    64'h0008);
    chk("w_access_done",    64'(DONE),        64'h0);
    tick();
    chk("w_done",         64'(DONE),        64'b0001);
    chk("w_err",          64'(RESP_ERR),    64'h0);
    chk("w_rdata_zero",   64'(RDATA),       64'h0);
    chk("w_psel_drop",    64'(apb.PSEL),    64'h0);
    chk("w_penable_drop", 64'(apb.PENABLE), 64'h0);
    REQ = '0;
    tick();
    chk("w_done_pulse", 64'(DONE), 64'h0);

    // 2. Read from requester 2 with 5 wait states
    set_cmd(2, 1'b0, 32'h0100_0004, 32'h0);
    REQ        = 4'b0100;
    apb.PREADY = 1'b0;
    tick();
    chk("r_setup_psel", 64'(apb.PSEL), 64'h0002);
    chk("r_setup_pwrite", 64'(apb.PWRITE), 64'h0);
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("r_wait_psel",    64'(apb.PSEL),    64'h0002);
      chk("r_wait_paddr",   64'(apb.PADDR),   64'h0100_0004);
      chk("r_wait_penable", 64'(apb.PENABLE), 64'h1);
      chk("r_wait_done",    64'(DONE),        64'h0);
      tick();
    end
    chk("r_last_penable", 64'(apb.PENABLE), 64'h1);
    apb.PREADY = 1'b1;
    apb.PRDATA = 32'h1234_5678;
    tick();
    chk("r_done",  64'(DONE),     64'b0100);
    chk("r_rdata", 64'(RDATA),    64'h1234_5678);
    chk("r_err",   64'(RESP_ERR), 64'h0);
    REQ        = '0;
    apb.PRDATA = 32'h0BAD_0BAD;
    tick();
    chk("r_rdata_clear", 64'(RDATA), 64'h0);

    // 4. Slave error from requester 3, top slot 15 (pointer is 3 here)
    set_cmd(3, 1'b1, 32'h0F00_0000, 32'h5555_AAAA);
    REQ         = 4'b1000;
    apb.PSLVERR = 1'b1;
    tick();
    chk("e_setup_psel", 64'(apb.PSEL), 64'h8000);
    tick();
    tick();
    chk("e_done", 64'(DONE),     64'b1000);
    chk("e_err",  64'(RESP_ERR), 64'h1);
    REQ         = '0;
    apb.PSLVERR = 1'b0;
    tick();

    // 3. Fairness: all four held continuously, pointer back at 0
    for (int i = 0; i < NREQ; i++) set_cmd(i, 1'b0, (32'(i) << 24) | 32'h40, 32'h0);
    apb.PRDATA = 32'hA5A5_0000;
    REQ        = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      tick();
      chk("f_psel", 64'(apb.PSEL), 64'(1) << (j % 4));
      tick();
      tick();
      chk("f_done", 64'(DONE), 64'(1) << (j % 4));
      chk("f_err",  64'(RESP_ERR), 64'h0);
      if (j == 4) REQ = '0;
    end
    tick();
    chk("f_idle_psel", 64'(apb.PSEL), 64'h0);

    // 5. Reset during ACCESS (pointer is 1; requester 2 wins, pointer -> 3)
    REQ        = 4'b0100;
    apb.PREADY = 1'b0;
    tick();
    chk("x_setup_psel", 64'(apb.PSEL), 64'h0004);
    tick();
    chk("x_access_penable", 64'(apb.PENABLE), 64'h1);
    PRESET = 1'b1;
    tick();
    chk("x_rst_psel",    64'(apb.PSEL),    64'h0);
    chk("x_rst_penable", 64'(apb.PENABLE), 64'h0);
    chk("x_rst_paddr",   64'(apb.PADDR),   64'h0);
    chk("x_rst_done",    64'(DONE),        64'h0);
    PRESET     = 1'b0;
    REQ        = 4'b1110;
    apb.PREADY = 1'b1;
    tick();
    chk("x_first_psel",  64'(apb.PSEL),  64'h0002);
    chk("x_first_paddr", 64'(apb.PADDR), 64'h0100_0040);
    chk("x_no_done",     64'(DONE),      64'h0);
    tick();
    tick();
    chk("x_first_done", 64'(DONE), 64'b0010);
    REQ = '0;
    tick();

`ifdef APB_ARB_TIMEOUT_EN
    // 6. PREADY stuck low: 16 ACCESS cycles then error completion
    apb.PREADY = 1'b0;
    apb.PRDATA = 32'hCAFE_F00D;
    REQ        = 4'b0100;
    tick();
    tick();
    for (int k = 0; k < 16; k++) begin
      chk("t_wait_done",    64'(DONE),        64'h0);
      chk("t_wait_penable", 64'(apb.PENABLE), 64'h1);
      tick();
    end
    chk("t_done",  64'(DONE),     64'b0100);
    chk("t_err",   64'(RESP_ERR), 64'h1);
    chk("t_rdata", 64'(RDATA),    64'h0);
    REQ = '0;
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
